stage2_sha: RTL



---
 rtl/sha256_pkg.sv | 48 ++++
 rtl/sha_round_func.sv | 26 ++
 rtl/stage2_sha.sv | 139 +++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared types, constants and round helper functions for the SHA-256 compression stage.
package sha256_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned CNT_W      = 6;
    localparam int unsigned ROUNDS_DEF = 64;
    localparam logic [CNT_W-1:0] ROUND_LAST = CNT_W'(ROUNDS_DEF - 1);

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam word_t SHA256_IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam word_t SHA224_IV [8] = '{
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t ch(input word_t e, input word_t f, input word_t g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic word_t maj(input word_t a, input word_t b, input word_t c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha_round_func.sv
// One SHA-256 compression round: produces the new a (T1+T2) and new e (d+T1).
module sha_round_func
    import sha256_pkg::*;
(
    input  word_t i_a,
    input  word_t i_b,
    input  word_t i_c,
    input  word_t i_d,
    input  word_t i_e,
    input  word_t i_f,
    input  word_t i_g,
    input  word_t i_h,
    input  word_t i_wk,
    output word_t o_a_nxt_c,
    output word_t o_e_nxt_c
);

    word_t w_t1;
    word_t w_t2;

    assign w_t1      = i_h + big_sigma1(i_e) + ch(i_e, i_f, i_g) + i_wk;
    assign w_t2      = big_sigma0(i_a) + maj(i_a, i_b, i_c);
    assign o_a_nxt_c = w_t1 + w_t2;
    assign o_e_nxt_c = i_d + w_t1;

endmodule

// File: rtl/stage2_sha.sv
// SHA-256 compression stage and round controller; SHA224_MODE_EN adds the
// sha224_sel port selecting the SHA-224 IV and truncating digest[31:0].
module stage2_sha
    import sha256_pkg::*;
#(
    parameter int unsigned ROUNDS = 32'(ROUND_LAST) + 32'd1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         first_block,
`ifdef SHA224_MODE_EN
    input  logic         sha224_sel,
`endif
    input  logic [31:0]  wk_info,
    output logic         sha_running,
    output logic [5:0]   state_counter,
    output logic         busy,
    output logic         digest_valid,
    output logic [255:0] digest
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUNDS - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_running;
    logic             r_busy;
    logic             r_valid;
    word_t            r_v [8];
    word_t            r_h [8];
    word_t            w_iv [8];
    word_t            w_a_nxt;
    word_t            w_e_nxt;
    word_t            w_h7;

`ifdef SHA224_MODE_EN
    logic             r_224;

    assign w_iv = sha224_sel ? SHA224_IV : SHA256_IV;
    assign w_h7 = r_224 ? '0 : r_h[7];
`else
    assign w_iv = SHA256_IV;
    assign w_h7 = r_h[7];
`endif

    sha_round_func u_round (
        .i_a       (r_v[0]),
        .i_b       (r_v[1]),
        .i_c       (r_v[2]),
        .i_d       (r_v[3]),
        .i_e       (r_v[4]),
        .i_f       (r_v[5]),
        .i_g       (r_v[6]),
        .i_h       (r_v[7]),
        .i_wk      (wk_info),
        .o_a_nxt_c (w_a_nxt),
        .o_e_nxt_c (w_e_nxt)
    );

    // Round controller with the working-variable and chaining-hash registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_running <= 1'b0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_v[i] <= '0;
                r_h[i] <= '0;
            end
`ifdef SHA224_MODE_EN
            r_224     <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                        r_busy    <= 1'b1;
                        r_cnt     <= '0;
                        if (first_block) begin
                            r_h <= w_iv;
                            r_v <= w_iv;
                        end else begin
                            r_v <= r_h;
                        end
`ifdef SHA224_MODE_EN
                        if (first_block) r_224 <= sha224_sel;
`endif
                    end
                end
                RUN: begin
                    r_v[0] <= w_a_nxt;
                    r_v[1] <= r_v[0];
                    r_v[2] <= r_v[1];
                    r_v[3] <= r_v[2];
                    r_v[4] <= w_e_nxt;
                    r_v[5] <= r_v[4];
                    r_v[6] <= r_v[5];
                    r_v[7] <= r_v[6];
                    if (r_cnt == LAST_CNT) begin
                        r_cnt     <= '0;
                        r_running <= 1'b0;
                        r_state   <= FINAL;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                FINAL: begin
                    for (int i = 0; i < 8; i++) begin
                        r_h[i] <= r_h[i] + r_v[i];
                    end
                    r_valid <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state   <= IDLE;
                    r_running <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign sha_running   = r_running;
    assign state_counter = r_cnt;
    assign busy          = r_busy;
    assign digest_valid  = r_valid;
    assign digest        = {r_h[0], r_h[1], r_h[2], r_h[3], r_h[4], r_h[5], r_h[6], w_h7};

endmodule
